// File: rtl/game_pkg.sv
// game_pkg: player state encodings and default geometry shared by game-logic blocks
package game_pkg;
    localparam logic [2:0] ST_GROUND = 3'd0;
    localparam logic [2:0] ST_RISE   = 3'd1;
    localparam logic [2:0] ST_HOVER  = 3'd2;
    localparam logic [2:0] ST_FALL   = 3'd3;
    localparam logic [2:0] ST_DEAD   = 3'd4;
    localparam int DEF_Y_W         = 7;
    localparam int DEF_JUMP_HEIGHT = 40;
    localparam int DEF_RISE_STEP   = 8;
    localparam int DEF_FALL_STEP   = 4;
    localparam int DEF_HOVER_TICKS = 3;
endpackage

// File: rtl/player_jump_fsm_key_edge_sync.sv
// key_edge_sync: 2-flop synchronizer followed by a one-cycle rising-edge pulse
module key_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);
    logic [2:0] s;
    always_ff @(posedge clk) s <= rst ? 3'b000 : {s[1:0], din};
    assign rise = s[1] & ~s[2];
endmodule

// File: rtl/player_jump_fsm.sv
// player_jump_fsm: tick-driven jump arc (ground, rise, hover, fall) with game-over freeze
module player_jump_fsm
    import game_pkg::*;
#(
    parameter int Y_W         = DEF_Y_W,
    parameter int JUMP_HEIGHT = DEF_JUMP_HEIGHT,
    parameter int RISE_STEP   = DEF_RISE_STEP,
    parameter int FALL_STEP   = DEF_FALL_STEP,
    parameter int HOVER_TICKS = DEF_HOVER_TICKS
) (
    input  logic           CLOCK_50,
    input  logic           reset,
    input  logic           tick,
    input  logic           key_press,
    input  logic           game_over,
    output logic [Y_W-1:0] player_y,
    output logic           airborne,
    output logic           jump_start,
    output logic           dead
);
    localparam int HC_W = $clog2(HOVER_TICKS + 2);
    localparam logic [Y_W-1:0]  JH = Y_W'(JUMP_HEIGHT);
    localparam logic [Y_W-1:0]  FS = Y_W'(FALL_STEP);
    localparam logic [Y_W:0]    RS = (Y_W + 1)'(RISE_STEP);
    localparam logic [HC_W-1:0] HT = HC_W'(HOVER_TICKS);
    localparam logic [2:0] APEX_ST = (HOVER_TICKS == 0) ? ST_FALL : ST_HOVER;
    localparam logic LAUNCH_APEX = RISE_STEP >= JUMP_HEIGHT;

    logic [2:0]      state;
    logic            pending;
    logic            key_rise;
    logic [HC_W-1:0] hover_cnt;
    logic [Y_W:0]    sum;

    key_edge_sync u_key (.clk(CLOCK_50), .rst(reset), .din(key_press), .rise(key_rise));

    assign sum = {1'b0, player_y} + RS;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state      <= ST_GROUND;
            player_y   <= '0;
            airborne   <= 1'b0;
            jump_start <= 1'b0;
            dead       <= 1'b0;
            pending    <= 1'b0;
            hover_cnt  <= '0;
        end else if (game_over && state != ST_DEAD) begin
            state      <= ST_DEAD;
            dead       <= 1'b1;
            pending    <= 1'b0;
            jump_start <= 1'b0;
        end else begin
            jump_start <= 1'b0;
            case (state)
                ST_GROUND:
                    if (tick && (pending || key_rise)) begin
                        state      <= LAUNCH_APEX ? APEX_ST : ST_RISE;
                        player_y   <= LAUNCH_APEX ? JH : RS[Y_W-1:0];
                        hover_cnt  <= HT;
                        airborne   <= 1'b1;
                        jump_start <= 1'b1;
                        pending    <= 1'b0;
                    end else if (key_rise) pending <= 1'b1;
                ST_RISE:
                    if (tick) begin
                        if (sum >= {1'b0, JH}) begin
                            player_y  <= JH;
                            hover_cnt <= HT;
                            state     <= APEX_ST;
                        end else player_y <= sum[Y_W-1:0];
                    end
                ST_HOVER:
                    if (tick) begin
                        hover_cnt <= hover_cnt - 1'b1;
                        if (hover_cnt == HC_W'(1)) state <= ST_FALL;
                    end
                ST_FALL:
                    if (tick) begin
                        if (player_y <= FS) begin
                            player_y <= '0;
                            airborne <= 1'b0;
                            state    <= ST_GROUND;
                        end else player_y <= player_y - FS;
                    end
                ST_DEAD:
                    // the restarting edge is consumed here and never becomes a jump request
                    if (key_rise && !game_over) begin
                        state    <= ST_GROUND;
                        player_y <= '0;
                        airborne <= 1'b0;
                        dead     <= 1'b0;
                        pending  <= 1'b0;
                    end
                default: state <= ST_GROUND;
            endcase
        end
    end
endmodule

// File: tb/tb_player_jump_fsm.sv
// tb_player_jump_fsm: vector table, corner sequences and random run against a trajectory model
module tb_player_jump_fsm;
    bit CLOCK_50, rst, key, gop, tick;
    logic [6:0] y [2];
    logic air [2], js [2], dd [2];

    player_jump_fsm dut (
        .CLOCK_50(CLOCK_50), .reset(rst), .tick(tick), .key_press(key), .game_over(gop),
        .player_y(y[0]), .airborne(air[0]), .jump_start(js[0]), .dead(dd[0])
    );
    player_jump_fsm #(.RISE_STEP(12), .HOVER_TICKS(0)) dut2 (
        .CLOCK_50(CLOCK_50), .reset(rst), .tick(tick), .key_press(key), .game_over(gop),
        .player_y(y[1]), .airborne(air[1]), .jump_start(js[1]), .dead(dd[1])
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int checks, failures;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", n, a, e, $time);
        end
    endtask

    // reference model: a jump is a precomputed list of heights, one consumed per tick
    int rs [2] = '{8, 12};
    int ht [2] = '{3, 0};
    int arc [2][64];
    int alen [2], apos [2], my [2];
    bit mair [2], mjs [2], mdead [2], mpend [2];
    bit k1, k2, k3, armed;

    task automatic build(input int i);
        int v, n;
        v = 0; n = 0;
        do begin
            v = (v + rs[i] > 40) ? 40 : v + rs[i];
            arc[i][n++] = v;
        end while (v < 40);
        repeat (ht[i]) arc[i][n++] = 40;
        while (v > 0) begin
            v = (v > 4) ? v - 4 : 0;
            arc[i][n++] = v;
        end
        alen[i] = n;
        apos[i] = 0;
    endtask

    task automatic pop(input int i);
        my[i] = arc[i][apos[i]++];
        if (apos[i] == alen[i]) mair[i] = 0;
    endtask

    task automatic model_step();
        bit rise;
        rise = k2 && !k3;
        if (rst) begin
            k1 = 0; k2 = 0; k3 = 0; armed = 1;
            for (int i = 0; i < 2; i++) begin
                my[i] = 0; mair[i] = 0; mjs[i] = 0; mdead[i] = 0; mpend[i] = 0;
            end
            return;
        end
        k3 = k2; k2 = k1; k1 = key;
        for (int i = 0; i < 2; i++) begin
            mjs[i] = 0;
            if (gop && !mdead[i]) begin
                mdead[i] = 1; mpend[i] = 0;
            end else if (mdead[i]) begin
                if (rise && !gop) begin mdead[i] = 0; my[i] = 0; mair[i] = 0; end
            end else if (!mair[i]) begin
                if (tick && (mpend[i] || rise)) begin
                    build(i); mair[i] = 1; pop(i); mjs[i] = 1; mpend[i] = 0;
                end else if (rise) mpend[i] = 1;
            end else if (tick) pop(i);
        end
    endtask

    task automatic cycle();
        @(posedge CLOCK_50);
        model_step();
        @(negedge CLOCK_50);
        if (armed) for (int i = 0; i < 2; i++) begin
            chk($sformatf("m%0d_y", i), 32'(y[i]), 32'(my[i]));
            chk($sformatf("m%0d_air", i), 32'(air[i]), 32'(mair[i]));
            chk($sformatf("m%0d_js", i), 32'(js[i]), 32'(mjs[i]));
            chk($sformatf("m%0d_dead", i), 32'(dd[i]), 32'(mdead[i]));
        end
    endtask

    task automatic pulse();
        tick = 1; cycle(); tick = 0;
        repeat (3) cycle();
    endtask

    typedef struct {
        bit rst, key, gop, tk;
        int ey, ey2, ejs;
        bit eair, edead;
    } vec_t;
    vec_t tbl [64];
    int nt;
    int a1 [18] = '{8, 16, 24, 32, 40, 40, 40, 40, 36, 32, 28, 24, 20, 16, 12, 8, 4, 0};
    int a2 [14] = '{12, 24, 36, 40, 36, 32, 28, 24, 20, 16, 12, 8, 4, 0};

    task automatic add(input bit r, k, g, t, input int ey, ey2, input bit ea, ed, input int ej);
        tbl[nt] = '{r, k, g, t, ey, ey2, ej, ea, ed};
        nt++;
    endtask

    task automatic run_block(input int n);
        int jc;
        rst = tbl[n].rst; key = tbl[n].key; gop = tbl[n].gop; jc = 0;
        for (int c = 0; c < 16; c++) begin
            tick = tbl[n].tk && c == 10;
            cycle();
            jc += 32'(js[0]);
        end
        tick = 0;
        chk($sformatf("v%0d_y", n), 32'(y[0]), 32'(tbl[n].ey));
        chk($sformatf("v%0d_y2", n), 32'(y[1]), 32'(tbl[n].ey2));
        chk($sformatf("v%0d_air", n), 32'(air[0]), 32'(tbl[n].eair));
        chk($sformatf("v%0d_dead", n), 32'(dd[0]), 32'(tbl[n].edead));
        chk($sformatf("v%0d_js", n), 32'(jc), 32'(tbl[n].ejs));
    endtask

    initial begin
        add(1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int j = 0; j < 18; j++)
            add(0, j == 0 || j == 2, 0, 1, a1[j], j < 14 ? a2[j] : 0, j < 17, 0, int'(j == 0));
        add(0, 0, 0, 1, 0, 0, 0, 0, 0);
        add(0, 1, 0, 1, 8, 12, 1, 0, 1);
        add(0, 0, 0, 1, 16, 24, 1, 0, 0);
        add(0, 0, 0, 1, 24, 36, 1, 0, 0);
        add(0, 0, 1, 1, 24, 36, 1, 1, 0);
        repeat (5) add(0, 0, 0, 1, 24, 36, 1, 1, 0);
        add(0, 1, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 1, 0, 0, 0, 0, 0);
        for (int j = 0; j < 18; j++)
            add(0, 1, 0, 1, a1[j], j < 14 ? a2[j] : 0, j < 17, 0, int'(j == 0));
        add(0, 1, 0, 1, 0, 0, 0, 0, 0);

        for (int n = 0; n < nt; n++) run_block(n);
        rst = 0; key = 0; gop = 0; tick = 0;
        repeat (4) cycle();

        key = 1; repeat (3) cycle(); key = 0;
        repeat (50) cycle();
        chk("late_wait_y", 32'(y[0]), 32'd0);
        tick = 1; cycle(); tick = 0;
        chk("late_launch_y", 32'(y[0]), 32'd8);
        chk("late_launch_js", 32'(js[0]), 32'd1);
        repeat (3) cycle();
        pulse(); pulse();
        gop = 1; tick = 1; cycle(); tick = 0;
        chk("go_tick_y", 32'(y[0]), 32'd24);
        chk("go_tick_dead", 32'(dd[0]), 32'd1);
        chk("go_tick_y2", 32'(y[1]), 32'd36);
        repeat (5) pulse();
        chk("dead_hold_y", 32'(y[0]), 32'd24);
        gop = 0; key = 1; repeat (4) cycle(); key = 0;
        chk("restart_y", 32'(y[0]), 32'd0);
        chk("restart_dead", 32'(dd[0]), 32'd0);
        pulse();
        chk("restart_nojump", 32'(air[0]), 32'd0);

        key = 1; repeat (4) cycle(); key = 0;
        repeat (6) pulse();
        chk("hover_y", 32'(y[0]), 32'd40);
        rst = 1; cycle(); rst = 0;
        chk("rst_mid_y", 32'(y[0]), 32'd0);
        chk("rst_mid_air", 32'(air[0]), 32'd0);
        chk("rst_mid_dead", 32'(dd[0]), 32'd0);
        key = 1; cycle(); cycle(); tick = 1; cycle(); tick = 0; key = 0;
        chk("coinc_y", 32'(y[0]), 32'd8);
        chk("coinc_js", 32'(js[0]), 32'd1);

        repeat (4000) begin
            rst = $urandom_range(599) == 0;
            tick = $urandom_range(4) == 0;
            if ($urandom_range(19) == 0) key = ~key;
            if ($urandom_range(79) == 0) gop = 1;
            else if ($urandom_range(9) == 0) gop = 0;
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/player_jump_fsm.md
Name: player_jump_fsm

Overview:
- Game-logic stage directly downstream of the game tick generator: consumes its one-cycle game-tick pulse and the player key, and produces the player's vertical position for the renderer and collision logic.
- Jump arc per tick: GROUND, then RISE, HOVER, FALL. Jump requests are edge-detected and buffered until the next tick.
- Freezes on game over; a key press restarts it from the ground.

Parameters:
- Y_W, 7, width of player_y.
- JUMP_HEIGHT, 40, apex height in pixels; must be less than 2^Y_W.
- RISE_STEP, 8, pixels added per tick while rising; must be at least 1.
- FALL_STEP, 4, pixels subtracted per tick while falling; must be at least 1.
- HOVER_TICKS, 3, ticks held at the apex; 0 is legal.

Ports:
- CLOCK_50  in  1  system clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- tick  in  1  one-CLOCK_50-cycle game-tick pulse from the tick generator.
- key_press  in  1  raw pushbutton, asynchronous and active-high.
- game_over  in  1  level from collision logic, synchronous to CLOCK_50.
- player_y  out  Y_W  height above ground; 0 means on the ground.
- airborne  out  1  high in RISE, HOVER or FALL.
- jump_start  out  1  one-cycle pulse when a jump is launched.
- dead  out  1  high in DEAD.

Behaviour:
- Reset:
  - state goes to GROUND; player_y, airborne, jump_start, dead, pending and hover_cnt go to 0.
  - The synchronizer flops are cleared.
  - Reset takes effect on any cycle, including mid-jump.
- key_press passes through a 2-flop synchronizer, then a rising-edge detector, producing key_rise as one cycle per press. A held key gives no further edges.
- pending flag:
  - Set on key_rise while state is GROUND.
  - key_rise in any other state is discarded, so there is no mid-air buffering.
  - Cleared when consumed, on entry to DEAD, and on restart.
- All outputs are registered. A transition taken on a cycle with tick=1 is visible on the next cycle.
- If key_rise and tick occur in the same cycle in GROUND, the jump launches on that tick: pending is treated as set.
- GROUND: on tick with pending set, go to RISE; player_y becomes min(RISE_STEP, JUMP_HEIGHT); jump_start=1 for exactly one cycle; pending is cleared.
- RISE: on tick, compute player_y + RISE_STEP with a Y_W+1-bit sum.
  - If sum >= JUMP_HEIGHT: player_y becomes JUMP_HEIGHT (saturate) and hover_cnt becomes HOVER_TICKS.
  - Then go to HOVER, or straight to FALL if HOVER_TICKS=0.
  - Otherwise player_y becomes the sum.
- Launch that reaches the apex: if the launch tick already saturates (RISE_STEP >= JUMP_HEIGHT), enter HOVER (or FALL) directly from GROUND.
- HOVER: on tick, decrement hover_cnt; when it reaches 0, go to FALL. The apex is held for exactly HOVER_TICKS ticks.
- FALL: on tick, if player_y <= FALL_STEP then player_y becomes 0 and the state goes to GROUND; otherwise player_y = player_y - FALL_STEP. No underflow.
- After landing, a new jump needs a fresh key_rise seen in GROUND.
- DEAD:
  - game_over=1 on any cycle, from any non-DEAD state, enters DEAD. This overrides a tick in the same cycle.
  - player_y is frozen at its current value, airborne holds, jump_start=0, dead=1.
  - Ticks are ignored.
- Restart: in DEAD, key_rise with game_over=0 goes to GROUND with player_y=0 and airborne=0. That edge is not counted as a jump.
- Between ticks, the state and player_y never change, except for entering DEAD and restarting.

Decomposition:
- Shared package game_pkg:
  - State encodings ST_GROUND, ST_RISE, ST_HOVER, ST_FALL, ST_DEAD as 3-bit localparams.
  - Default geometry constants, shared with the renderer and collision logic.
- One sub-module, key_edge_sync: 2-flop synchronizer plus rising-edge pulse, reused for other buttons.
- Everything else lives in a single always block with a registered state machine.

Test Plan:
- Defaults; reset; press; 20 ticks 16 cycles apart -> player_y = 8,16,24,32,40, then 40 for 3 ticks, then 36, 32, ..., 0 over 10 ticks. jump_start pulses once; airborne falls together with landing.
- RISE_STEP=12 -> player_y = 12, 24, 36, then 40 (saturates). HOVER_TICKS=0 -> FALL begins on the tick after the apex.
- Key held for 100 cycles across a landing -> a single jump only; a second press mid-air is ignored; a press in GROUND, then a tick 50 cycles later -> launch on that tick.
- game_over asserted at y=24 in the same cycle as a tick -> dead=1, y stays 24 through 5 ticks; key press -> GROUND, y=0, and no jump on the next tick.
- reset asserted mid-HOVER -> next cycle y=0, GROUND, and all outputs at 0; key_rise and tick in the same cycle from GROUND -> launch, y=8.
